// File: rtl/maze_pkg.sv
// maze_pkg: shared FSM encoding, colours and geometry helpers for the maze engine
package maze_pkg;
  typedef enum logic [1:0] {IDLE, CALC, SCAN, COMMIT} state_t;
  typedef struct packed {
    logic [11:0] x0;
    logic [11:0] x1;
    logic [11:0] y0;
    logic [11:0] y1;
  } rect_t;
  localparam logic [11:0] C_BLACK = 12'h000;
  localparam logic [11:0] C_WHITE = 12'hFFF;
  localparam logic [11:0] C_GREEN = 12'h0F0;
  localparam logic [11:0] C_BLUE  = 12'h008;
  function automatic rect_t wall_rect(input int k, input int gw, input int gh, input int cl2,
                                      input int ox, input int oy, input int wt);
    int nh, c, r, x0, x1, y0, y1;
    rect_t w;
    nh = gw * (gh - 1);
    if (k < nh) begin
      c  = k % gw;
      r  = k / gw;
      x0 = ox + (c << cl2);
      x1 = x0 + (1 << cl2) - 1;
      y0 = oy + ((r + 1) << cl2);
      y1 = y0 + wt - 1;
    end else begin
      c  = (k - nh) % (gw - 1);
      r  = (k - nh) / (gw - 1);
      x0 = ox + ((c + 1) << cl2);
      x1 = x0 + wt - 1;
      y0 = oy + (r << cl2);
      y1 = y0 + (1 << cl2) - 1;
    end
    w.x0 = 12'(x0);
    w.x1 = 12'(x1);
    w.y0 = 12'(y0);
    w.y1 = 12'(y1);
    return w;
  endfunction
  function automatic logic [10:0] start_coord(input int origin, input int idx, input int cl2, input int pw);
    return 11'(origin + (idx << cl2) + (((1 << cl2) - pw) / 2));
  endfunction
  function automatic int cell_lo(input int origin, input int idx, input int cl2);
    return origin + (idx << cl2);
  endfunction
endpackage

// File: rtl/maze_renderer.sv
// maze_renderer: registered pixel colour from player box, border, snapshot walls and goal cell
module maze_renderer
  import maze_pkg::*;
#(
  parameter int GRID_W    = 5,
  parameter int GRID_H    = 5,
  parameter int CELL_LOG2 = 6,
  parameter int ORIGIN_X  = 120,
  parameter int ORIGIN_Y  = 0,
  parameter int WALL_T    = 2,
  parameter int PWIDTH    = 20,
  parameter int GOAL_COL  = 4,
  parameter int GOAL_ROW  = 0
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [10:0]                      i_hcnt,
  input  logic [10:0]                      i_vcnt,
  input  logic                             i_blank,
  input  logic [10:0]                      i_px,
  input  logic [10:0]                      i_py,
  input  logic [GRID_W*(GRID_H-1)-1:0]     i_hs,
  input  logic [(GRID_W-1)*GRID_H-1:0]     i_vs,
  output logic [11:0]                      o_rgb
);
  localparam int CELL = 1 << CELL_LOG2;
  localparam int PF_W = GRID_W * CELL;
  localparam int PF_H = GRID_H * CELL;
  int w_rx, w_ry, w_cc, w_cr;
  logic [GRID_W*(GRID_H-1)-1:0] w_hsh;
  logic [(GRID_W-1)*GRID_H-1:0] w_vsh;
  logic w_in, w_player, w_border, w_wall, w_goal;
  logic [11:0] w_rgb, r_rgb;
  // classify the current pixel; a wall pixel at a cell's leading edge belongs to the previous cell
  always_comb begin
    w_rx     = int'(i_hcnt) - ORIGIN_X;
    w_ry     = int'(i_vcnt) - ORIGIN_Y;
    w_cc     = w_rx >>> CELL_LOG2;
    w_cr     = w_ry >>> CELL_LOG2;
    w_in     = w_rx >= 0 && w_rx < PF_W && w_ry >= 0 && w_ry < PF_H;
    w_player = int'(i_hcnt) >= int'(i_px) && int'(i_hcnt) <= int'(i_px) + PWIDTH - 1 &&
               int'(i_vcnt) >= int'(i_py) && int'(i_vcnt) <= int'(i_py) + PWIDTH - 1;
    w_border = w_in && (w_rx < WALL_T || w_rx >= PF_W - WALL_T || w_ry < WALL_T || w_ry >= PF_H - WALL_T);
    w_hsh    = i_hs >> ((w_cr > 0 ? w_cr - 1 : 0) * GRID_W + (w_cc > 0 ? w_cc : 0));
    w_vsh    = i_vs >> ((w_cr > 0 ? w_cr : 0) * (GRID_W - 1) + (w_cc > 0 ? w_cc - 1 : 0));
    w_wall   = w_in && ((w_cr > 0 && (w_ry & (CELL - 1)) < WALL_T && w_hsh[0]) ||
                        (w_cc > 0 && (w_rx & (CELL - 1)) < WALL_T && w_vsh[0]));
    w_goal   = w_in && w_cc == GOAL_COL && w_cr == GOAL_ROW;
    w_rgb    = i_blank ? C_BLACK : (w_player || w_border) ? C_WHITE : w_wall ? C_GREEN :
               w_goal ? C_BLUE : C_BLACK;
  end
  // one-cycle registered colour
  always_ff @(posedge i_clk) r_rgb <= i_rst ? C_BLACK : w_rgb;
  assign o_rgb = r_rgb;
endmodule

// File: rtl/maze_engine.sv
// maze_engine: player move/wall-scan FSM and VGA colour; MAZE_COLLIDE_HOLD_EN makes walls block instead of respawning
module maze_engine
  import maze_pkg::*;
#(
  parameter int GRID_W    = 5,
  parameter int GRID_H    = 5,
  parameter int CELL_LOG2 = 6,
  parameter int ORIGIN_X  = 120,
  parameter int ORIGIN_Y  = 0,
  parameter int WALL_T    = 2,
  parameter int PWIDTH    = 20,
  parameter int MOVE_W    = 5,
  parameter int START_COL = 0,
  parameter int START_ROW = 4,
  parameter int GOAL_COL  = 4,
  parameter int GOAL_ROW  = 0
) (
  input  logic                          pixel_clk,
  input  logic                          reset,
  input  logic                          frame_tick,
  input  logic                          run,
  input  logic                          pos_reset,
  input  logic signed [MOVE_W-1:0]      move_x,
  input  logic signed [MOVE_W-1:0]      move_y,
  input  logic [GRID_W*(GRID_H-1)-1:0]  h_walls,
  input  logic [(GRID_W-1)*GRID_H-1:0]  v_walls,
  input  logic [10:0]                   hcnt,
  input  logic [10:0]                   vcnt,
  input  logic                          blank,
  output logic [3:0]                    vga_r,
  output logic [3:0]                    vga_g,
  output logic [3:0]                    vga_b,
  output logic [10:0]                   player_x,
  output logic [10:0]                   player_y,
  output logic                          busy,
  output logic                          collision,
  output logic                          goal,
  output logic [7:0]                    hit_count,
  output logic                          frame_overrun
);
  localparam int CELL = 1 << CELL_LOG2;
  localparam int NH   = GRID_W * (GRID_H - 1);
  localparam int NV   = (GRID_W - 1) * GRID_H;
  localparam int NT   = NH + NV;
  localparam int KW   = $clog2(NT);
  localparam logic [10:0] START_X = start_coord(ORIGIN_X, START_COL, CELL_LOG2, PWIDTH);
  localparam logic [10:0] START_Y = start_coord(ORIGIN_Y, START_ROW, CELL_LOG2, PWIDTH);
  localparam int GX0 = cell_lo(ORIGIN_X, GOAL_COL, CELL_LOG2);
  localparam int GY0 = cell_lo(ORIGIN_Y, GOAL_ROW, CELL_LOG2);
`ifdef MAZE_COLLIDE_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  state_t r_state, w_next;
  logic [10:0] r_x, r_y;
  logic signed [MOVE_W-1:0] r_mx, r_my;
  logic [NH-1:0] r_hs;
  logic [NV-1:0] r_vs;
  logic signed [11:0] r_cx, r_cy, w_cx, w_cy;
  logic [KW-1:0] r_k;
  logic r_hit, r_coll, r_goal, r_ovr;
  logic [7:0] r_hits;
  logic w_start, w_inb, w_whit, w_goal_in, w_last;
  logic [NT-1:0] w_all;
  logic [11:0] w_rgb;
  rect_t w_rect;
  // candidate position, bounds, wall overlap for index k, goal test and next state
  always_comb begin
    w_start   = frame_tick && run;
    w_cx      = $signed({1'b0, r_x}) + $signed({{(12-MOVE_W){r_mx[MOVE_W-1]}}, r_mx});
    w_cy      = $signed({1'b0, r_y}) + $signed({{(12-MOVE_W){r_my[MOVE_W-1]}}, r_my});
    w_inb     = int'(w_cx) >= ORIGIN_X + WALL_T && int'(w_cx) + PWIDTH - 1 <= ORIGIN_X + GRID_W*CELL - 1 - WALL_T &&
                int'(w_cy) >= ORIGIN_Y + WALL_T && int'(w_cy) + PWIDTH - 1 <= ORIGIN_Y + GRID_H*CELL - 1 - WALL_T;
    w_all     = {r_vs, r_hs};
    w_rect    = wall_rect(int'(r_k), GRID_W, GRID_H, CELL_LOG2, ORIGIN_X, ORIGIN_Y, WALL_T);
    w_whit    = w_all[r_k] &&
                int'(w_rect.x0) <= int'(r_cx) + PWIDTH - 1 && int'(w_rect.x1) >= int'(r_cx) &&
                int'(w_rect.y0) <= int'(r_cy) + PWIDTH - 1 && int'(w_rect.y1) >= int'(r_cy);
    w_last    = r_k == KW'(NT - 1);
    w_goal_in = int'(r_cx) >= GX0 && int'(r_cx) + PWIDTH - 1 <= GX0 + CELL - 1 &&
                int'(r_cy) >= GY0 && int'(r_cy) + PWIDTH - 1 <= GY0 + CELL - 1;
    w_next    = pos_reset ? IDLE :
                r_state == IDLE ? (w_start ? CALC : IDLE) :
                r_state == CALC ? (w_inb ? SCAN : COMMIT) :
                r_state == SCAN ? (w_last ? COMMIT : SCAN) : IDLE;
  end
  // FSM state register
  always_ff @(posedge pixel_clk) r_state <= reset ? IDLE : w_next;
  // snapshots, candidate, scan index, position and status updates
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      r_x    <= START_X;
      r_y    <= START_Y;
      r_mx   <= '0;
      r_my   <= '0;
      r_hs   <= '0;
      r_vs   <= '0;
      r_cx   <= '0;
      r_cy   <= '0;
      r_k    <= '0;
      r_hit  <= 1'b0;
      r_coll <= 1'b0;
      r_goal <= 1'b0;
      r_hits <= '0;
      r_ovr  <= 1'b0;
    end else begin
      r_coll <= 1'b0;
      r_goal <= 1'b0;
      if (frame_tick && r_state != IDLE) r_ovr <= 1'b1;
      if (pos_reset) begin
        r_x <= START_X;
        r_y <= START_Y;
      end else if (r_state == IDLE && w_start) begin
        r_mx <= move_x;
        r_my <= move_y;
        r_hs <= h_walls;
        r_vs <= v_walls;
      end else if (r_state == CALC) begin
        r_cx  <= w_cx;
        r_cy  <= w_cy;
        r_hit <= !w_inb;
        r_k   <= '0;
      end else if (r_state == SCAN) begin
        r_hit <= r_hit || w_whit;
        r_k   <= r_k + KW'(1);
      end else if (r_state == COMMIT) begin
        r_x    <= r_hit ? (HOLD ? r_x : START_X) : w_goal_in ? START_X : r_cx[10:0];
        r_y    <= r_hit ? (HOLD ? r_y : START_Y) : w_goal_in ? START_Y : r_cy[10:0];
        r_coll <= r_hit;
        r_goal <= !r_hit && w_goal_in;
        r_hits <= r_hits + {7'd0, r_hit && r_hits != 8'hFF};
      end
    end
  end
  maze_renderer #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .CELL_LOG2(CELL_LOG2), .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y),
    .WALL_T(WALL_T), .PWIDTH(PWIDTH), .GOAL_COL(GOAL_COL), .GOAL_ROW(GOAL_ROW)
  ) u_render (
    .i_clk(pixel_clk), .i_rst(reset), .i_hcnt(hcnt), .i_vcnt(vcnt), .i_blank(blank),
    .i_px(r_x), .i_py(r_y), .i_hs(r_hs), .i_vs(r_vs), .o_rgb(w_rgb)
  );
  assign {vga_r, vga_g, vga_b} = w_rgb;
  assign player_x      = r_x;
  assign player_y      = r_y;
  assign busy          = r_state != IDLE;
  assign collision     = r_coll;
  assign goal          = r_goal;
  assign hit_count     = r_hits;
  assign frame_overrun = r_ovr;
endmodule

// File: tb/tb_maze_engine.sv
// tb_maze_engine: directed self-checking bench for maze_engine (6-bit moves so -21/+-31 are representable)
module tb_maze_engine;
  logic pixel_clk = 1'b0, reset = 1'b1, frame_tick = 1'b0, run = 1'b0, pos_reset = 1'b0, blank = 1'b1;
  logic signed [5:0] move_x = '0, move_y = '0;
  logic [19:0] h_walls = '0, v_walls = '0;
  logic [10:0] hcnt = '0, vcnt = '0;
  logic [3:0] vga_r, vga_g, vga_b;
  logic [10:0] player_x, player_y;
  logic busy, collision, goal, frame_overrun;
  logic [7:0] hit_count;
  logic [11:0] rgb;
  int n_checks = 0, n_fail = 0;
  assign rgb = {vga_r, vga_g, vga_b};
  always #5 pixel_clk = ~pixel_clk;
  maze_engine #(.MOVE_W(6)) dut (
    .pixel_clk(pixel_clk), .reset(reset), .frame_tick(frame_tick), .run(run), .pos_reset(pos_reset),
    .move_x(move_x), .move_y(move_y), .h_walls(h_walls), .v_walls(v_walls),
    .hcnt(hcnt), .vcnt(vcnt), .blank(blank), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .player_x(player_x), .player_y(player_y), .busy(busy), .collision(collision), .goal(goal),
    .hit_count(hit_count), .frame_overrun(frame_overrun)
  );
  task tick_and_wait(output int cyc);
    @(negedge pixel_clk) frame_tick = 1'b1;
    @(negedge pixel_clk) frame_tick = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      cyc++;
      @(negedge pixel_clk);
    end
  endtask
  task pulse_pos_reset;
    @(negedge pixel_clk) pos_reset = 1'b1;
    @(negedge pixel_clk) pos_reset = 1'b0;
  endtask
  task test_reset;
    reset = 1'b1; blank = 1'b0; hcnt = 11'd150; vcnt = 11'd280; run = 1'b1;
    repeat (3) @(negedge pixel_clk);
    n_checks++; if (player_x !== 11'd142) begin n_fail++; $display("FAIL reset_x: got %0d want 142", player_x); end
    n_checks++; if (player_y !== 11'd278) begin n_fail++; $display("FAIL reset_y: got %0d want 278", player_y); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (hit_count !== 8'd0) begin n_fail++; $display("FAIL reset_hits: got %0d want 0", hit_count); end
    n_checks++; if (frame_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b want 0", frame_overrun); end
    n_checks++; if (rgb !== 12'h000) begin n_fail++; $display("FAIL reset_rgb: got %h want 000", rgb); end
    n_checks++; if ({collision, goal} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b want 00", {collision, goal}); end
    reset = 1'b0; blank = 1'b1;
  endtask
  task test_move;
    int cyc;
    h_walls = '0; v_walls = '0; move_x = 6'sd3; move_y = 6'sd0;
    tick_and_wait(cyc);
    n_checks++; if (cyc !== 42) begin n_fail++; $display("FAIL move_latency: got %0d want 42", cyc); end
    n_checks++; if (player_x !== 11'd145) begin n_fail++; $display("FAIL move_x: got %0d want 145", player_x); end
    n_checks++; if (player_y !== 11'd278) begin n_fail++; $display("FAIL move_y: got %0d want 278", player_y); end
    n_checks++; if ({collision, goal} !== 2'b00) begin n_fail++; $display("FAIL move_pulses: got %b want 00", {collision, goal}); end
  endtask
  task test_collision;
    int cyc;
    pulse_pos_reset();
    n_checks++; if (player_x !== 11'd142) begin n_fail++; $display("FAIL posreset_x: got %0d want 142", player_x); end
    h_walls = '0; h_walls[15] = 1'b1; move_x = 6'sd0; move_y = -6'sd21;
    tick_and_wait(cyc);
    n_checks++; if (cyc !== 42) begin n_fail++; $display("FAIL coll_latency: got %0d want 42", cyc); end
    n_checks++; if (collision !== 1'b1) begin n_fail++; $display("FAIL coll_pulse: got %b want 1", collision); end
    n_checks++; if ({player_x, player_y} !== {11'd142, 11'd278}) begin n_fail++; $display("FAIL coll_pos: got %0d,%0d want 142,278", player_x, player_y); end
    n_checks++; if (hit_count !== 8'd1) begin n_fail++; $display("FAIL coll_hits: got %0d want 1", hit_count); end
    @(negedge pixel_clk);
    n_checks++; if (collision !== 1'b0) begin n_fail++; $display("FAIL coll_one_cycle: got %b want 0", collision); end
  endtask
  task test_bounds;
    int cyc;
    h_walls = '0; move_x = -6'sd20; move_y = 6'sd0;
    tick_and_wait(cyc);
    n_checks++; if (cyc !== 42) begin n_fail++; $display("FAIL edge_latency: got %0d want 42", cyc); end
    n_checks++; if (player_x !== 11'd122) begin n_fail++; $display("FAIL edge_x: got %0d want 122", player_x); end
    n_checks++; if (collision !== 1'b0) begin n_fail++; $display("FAIL edge_pulse: got %b want 0", collision); end
    pulse_pos_reset();
    move_x = -6'sd21;
    tick_and_wait(cyc);
    n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL oob_latency: got %0d want 2", cyc); end
    n_checks++; if (collision !== 1'b1) begin n_fail++; $display("FAIL oob_pulse: got %b want 1", collision); end
    n_checks++; if (player_x !== 11'd142) begin n_fail++; $display("FAIL oob_x: got %0d want 142", player_x); end
    n_checks++; if (hit_count !== 8'd2) begin n_fail++; $display("FAIL oob_hits: got %0d want 2", hit_count); end
  endtask
  task test_goal;
    int cyc;
    h_walls = '0; move_x = 6'sd31; move_y = -6'sd31;
    for (int k = 1; k <= 8; k++) begin
      tick_and_wait(cyc);
      if (k < 8) begin
        n_checks++; if (int'(player_x) !== 142 + 31*k || int'(player_y) !== 278 - 31*k || goal !== 1'b0) begin
          n_fail++; $display("FAIL goal_step%0d: got %0d,%0d goal %b want %0d,%0d goal 0", k, player_x, player_y, goal, 142 + 31*k, 278 - 31*k);
        end
      end else begin
        n_checks++; if (goal !== 1'b1) begin n_fail++; $display("FAIL goal_pulse: got %b want 1", goal); end
        n_checks++; if ({player_x, player_y} !== {11'd142, 11'd278}) begin n_fail++; $display("FAIL goal_respawn: got %0d,%0d want 142,278", player_x, player_y); end
        n_checks++; if (collision !== 1'b0) begin n_fail++; $display("FAIL goal_coll: got %b want 0", collision); end
      end
    end
    @(negedge pixel_clk);
    n_checks++; if (goal !== 1'b0) begin n_fail++; $display("FAIL goal_one_cycle: got %b want 0", goal); end
  endtask
  task test_overrun;
    int cyc;
    move_x = 6'sd3; move_y = 6'sd0;
    @(negedge pixel_clk) frame_tick = 1'b1;
    @(negedge pixel_clk) frame_tick = 1'b0;
    repeat (9) @(negedge pixel_clk);
    frame_tick = 1'b1;
    @(negedge pixel_clk) frame_tick = 1'b0;
    n_checks++; if (frame_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", frame_overrun); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ovr_busy: got %b want 1", busy); end
    cyc = 0;
    while (busy && cyc < 100) begin cyc++; @(negedge pixel_clk); end
    repeat (50) @(negedge pixel_clk);
    n_checks++; if (player_x !== 11'd145) begin n_fail++; $display("FAIL ovr_single_move: got %0d want 145", player_x); end
    n_checks++; if (busy !== 1'b0 || frame_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got busy %b ovr %b want 0 1", busy, frame_overrun); end
  endtask
  task test_pos_reset;
    @(negedge pixel_clk) begin pos_reset = 1'b1; frame_tick = 1'b1; end
    @(negedge pixel_clk) begin pos_reset = 1'b0; frame_tick = 1'b0; end
    n_checks++; if (player_x !== 11'd142 || busy !== 1'b0) begin n_fail++; $display("FAIL pr_tick: got x %0d busy %b want 142 0", player_x, busy); end
    repeat (45) @(negedge pixel_clk);
    n_checks++; if (player_x !== 11'd142) begin n_fail++; $display("FAIL pr_tick_ignored: got %0d want 142", player_x); end
    @(negedge pixel_clk) frame_tick = 1'b1;
    @(negedge pixel_clk) frame_tick = 1'b0;
    repeat (5) @(negedge pixel_clk);
    pos_reset = 1'b1;
    @(negedge pixel_clk) pos_reset = 1'b0;
    n_checks++; if (busy !== 1'b0 || player_x !== 11'd142) begin n_fail++; $display("FAIL pr_midscan: got busy %b x %0d want 0 142", busy, player_x); end
    repeat (45) @(negedge pixel_clk);
    n_checks++; if (player_x !== 11'd142 || hit_count !== 8'd2) begin n_fail++; $display("FAIL pr_abort: got x %0d hits %0d want 142 2", player_x, hit_count); end
  endtask
  task test_render;
    int cyc;
    int th[12] = '{150, 150, 120, 130, 130, 130, 400, 439, 200, 248, 247, 250};
    int tv[12] = '{280, 280, 100, 256, 257, 258, 30, 30, 100, 150, 150, 150};
    logic tb[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [11:0] tc[12] = '{12'hFFF, 12'h000, 12'hFFF, 12'h0F0, 12'h0F0, 12'h000, 12'h008, 12'hFFF, 12'h000, 12'h0F0, 12'h000, 12'h000};
    h_walls = '0; h_walls[15] = 1'b1; v_walls = '0; v_walls[9] = 1'b1; move_x = 6'sd0; move_y = 6'sd0;
    tick_and_wait(cyc);
    n_checks++; if (collision !== 1'b0 || player_x !== 11'd142) begin n_fail++; $display("FAIL snap_tick: got coll %b x %0d want 0 142", collision, player_x); end
    for (int i = 0; i < 12; i++) begin
      hcnt = 11'(th[i]); vcnt = 11'(tv[i]); blank = tb[i];
      @(negedge pixel_clk);
      n_checks++; if (rgb !== tc[i]) begin n_fail++; $display("FAIL render_%0d_%0d_b%0b: got %h want %h", th[i], tv[i], tb[i], rgb, tc[i]); end
    end
    blank = 1'b1;
  endtask
  task test_saturation;
    int cyc;
    h_walls = '0; v_walls = '0; move_x = -6'sd21; move_y = 6'sd0;
    repeat (260) tick_and_wait(cyc);
    n_checks++; if (hit_count !== 8'd255) begin n_fail++; $display("FAIL sat_hits: got %0d want 255", hit_count); end
    n_checks++; if (collision !== 1'b1) begin n_fail++; $display("FAIL sat_pulse: got %b want 1", collision); end
  endtask
  task test_reset_midscan;
    move_x = 6'sd3; move_y = 6'sd0;
    @(negedge pixel_clk) frame_tick = 1'b1;
    @(negedge pixel_clk) frame_tick = 1'b0;
    repeat (5) @(negedge pixel_clk);
    reset = 1'b1;
    @(negedge pixel_clk) reset = 1'b0;
    n_checks++; if (busy !== 1'b0 || hit_count !== 8'd0 || frame_overrun !== 1'b0) begin n_fail++; $display("FAIL rst_mid: got busy %b hits %0d ovr %b want 0 0 0", busy, hit_count, frame_overrun); end
    repeat (45) @(negedge pixel_clk);
    n_checks++; if (player_x !== 11'd142 || collision !== 1'b0) begin n_fail++; $display("FAIL rst_abort: got x %0d coll %b want 142 0", player_x, collision); end
  endtask
  initial begin
    test_reset();
    test_move();
    test_collision();
    test_bounds();
    test_goal();
    test_overrun();
    test_pos_reset();
    test_render();
    test_saturation();
    test_reset_midscan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
